// File: rtl/xif_coproc_pipe.sv
// xif_coproc_pipe: eXtension-interface coprocessor with an in-order queue of
// up to DEPTH offloaded instructions. Each entry tracks commit/kill by ID and
// is executed only once it reaches the head and has been committed.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   issue_*                            offload request and combinational response
//   commit_valid/commit_id/commit_kill commit strobe per instruction ID
//   mem_*                              word load/store request and response channel
//   result_*                           in-order writeback channel
//
// Ops: custom-0 funct3 000 MAGIC, 001 ADD, 010 XOR, 011 MAXU;
//      custom-1 funct3 000 RMLD (load word), 001 RMST (store word).
module xif_coproc_pipe #(
  parameter int unsigned     DEPTH      = 4,
  parameter int unsigned     X_ID_WIDTH = 4,
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] MAGIC      = XLEN'(32'hDEADBEEF)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // Issue
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [31:0]           issue_instr,
  input  logic [X_ID_WIDTH-1:0] issue_id,
  input  logic [XLEN-1:0]       issue_rs0,
  input  logic [XLEN-1:0]       issue_rs1,
  output logic                  issue_accept,
  output logic                  issue_writeback,
  output logic                  issue_loadstore,
  // Commit
  input  logic                  commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  // Memory request
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [X_ID_WIDTH-1:0] mem_id,
  output logic [XLEN-1:0]       mem_addr,
  output logic                  mem_we,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [XLEN/8-1:0]     mem_be,
  // Memory response
  input  logic                  mem_result_valid,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  mem_result_err,
  // Result
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [X_ID_WIDTH-1:0] result_id,
  output logic [XLEN-1:0]       result_data,
  output logic [4:0]            result_rd,
  output logic                  result_we,
  output logic                  result_err
);

  localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

  localparam logic [6:0] OpcCustom0 = 7'b0001011;
  localparam logic [6:0] OpcCustom1 = 7'b0101011;

  typedef enum logic [2:0] {OpMagic, OpAdd, OpXor, OpMaxu, OpLoad, OpStore} op_e;

  typedef enum logic [2:0] {
    StIdle, StDrop, StExec, StMemReq, StMemWait, StResult
  } state_e;

  // ---------------------------------------------------------------------------
  // Decode (combinational from issue_instr)
  // ---------------------------------------------------------------------------
  logic dec_accept, dec_wb, dec_ls;
  op_e  dec_op;

  always_comb begin
    dec_accept = 1'b0;
    dec_wb     = 1'b0;
    dec_ls     = 1'b0;
    dec_op     = OpMagic;
    case (issue_instr[6:0])
      OpcCustom0: begin
        case (issue_instr[14:12])
          3'b000: begin dec_accept = 1'b1; dec_wb = 1'b1; dec_op = OpMagic; end
          3'b001: begin dec_accept = 1'b1; dec_wb = 1'b1; dec_op = OpAdd;   end
          3'b010: begin dec_accept = 1'b1; dec_wb = 1'b1; dec_op = OpXor;   end
          3'b011: begin dec_accept = 1'b1; dec_wb = 1'b1; dec_op = OpMaxu;  end
          default: ;
        endcase
      end
      OpcCustom1: begin
        case (issue_instr[14:12])
          3'b000: begin
            dec_accept = 1'b1; dec_wb = 1'b1; dec_ls = 1'b1; dec_op = OpLoad;
          end
          3'b001: begin
            dec_accept = 1'b1; dec_ls = 1'b1; dec_op = OpStore;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign issue_accept    = dec_accept;
  assign issue_writeback = dec_wb;
  assign issue_loadstore = dec_ls;

  // Upper instruction bits carry no information for these ops.
  logic unused_instr;
  assign unused_instr = ^issue_instr[31:15];

  // ---------------------------------------------------------------------------
  // Instruction queue
  // ---------------------------------------------------------------------------
  logic [X_ID_WIDTH-1:0] q_id_q  [DEPTH];
  op_e                   q_op_q  [DEPTH];
  logic [XLEN-1:0]       q_rs0_q [DEPTH];
  logic [XLEN-1:0]       q_rs1_q [DEPTH];
  logic [4:0]            q_rd_q  [DEPTH];
  logic [DEPTH-1:0]      q_valid_q, q_cmt_q, q_kill_q;
  logic [PtrW-1:0]       head_q, tail_q;
  logic [PtrW:0]         count_q;

  logic enq, pop;

  // Registered count only: a pop in the same cycle does not reopen a full queue.
  assign issue_ready = (count_q < DepthCnt);
  assign enq         = issue_valid & issue_ready & dec_accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_id_q[i]  <= '0;
        q_op_q[i]  <= OpMagic;
        q_rs0_q[i] <= '0;
        q_rs1_q[i] <= '0;
        q_rd_q[i]  <= '0;
      end
      q_valid_q <= '0;
      q_cmt_q   <= '0;
      q_kill_q  <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      if (commit_valid) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (q_valid_q[i] && (q_id_q[i] == commit_id)) begin
            q_cmt_q[i] <= 1'b1;
            if (commit_kill) q_kill_q[i] <= 1'b1;
          end
        end
      end
      // The enqueue slot is never a valid entry, so its flag clear cannot
      // collide with a commit above.
      if (enq) begin
        q_id_q[tail_q]    <= issue_id;
        q_op_q[tail_q]    <= dec_op;
        q_rs0_q[tail_q]   <= issue_rs0;
        q_rs1_q[tail_q]   <= issue_rs1;
        q_rd_q[tail_q]    <= issue_instr[11:7];
        q_valid_q[tail_q] <= 1'b1;
        q_cmt_q[tail_q]   <= 1'b0;
        q_kill_q[tail_q]  <= 1'b0;
        tail_q            <= tail_q + 1'b1;
      end
      if (pop) begin
        q_valid_q[head_q] <= 1'b0;
        head_q            <= head_q + 1'b1;
      end
      case ({enq, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head entry view
  // ---------------------------------------------------------------------------
  logic [X_ID_WIDTH-1:0] head_id;
  op_e                   head_op;
  logic [XLEN-1:0]       head_rs0, head_rs1;
  logic [4:0]            head_rd;
  logic                  head_valid, head_match, head_cmt, head_kill, head_is_mem;

  assign head_id    = q_id_q[head_q];
  assign head_op    = q_op_q[head_q];
  assign head_rs0   = q_rs0_q[head_q];
  assign head_rs1   = q_rs1_q[head_q];
  assign head_rd    = q_rd_q[head_q];
  assign head_valid = q_valid_q[head_q];

  // Bypass a same-cycle commit so the head leaves IDLE one cycle after it.
  assign head_match  = commit_valid & head_valid & (commit_id == head_id);
  assign head_cmt    = q_cmt_q[head_q] | head_match;
  assign head_kill   = q_kill_q[head_q] | (head_match & commit_kill);
  assign head_is_mem = (head_op == OpLoad) || (head_op == OpStore);

  logic [XLEN-1:0] alu_result;

  always_comb begin
    alu_result = MAGIC;
    case (head_op)
      OpAdd:   alu_result = head_rs0 + head_rs1;
      OpXor:   alu_result = head_rs0 ^ head_rs1;
      OpMaxu:  alu_result = (head_rs0 > head_rs1) ? head_rs0 : head_rs1;
      default: alu_result = MAGIC;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Head FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   res_load_exec, res_load_mem;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (head_valid && head_cmt) begin
          if (head_kill)        state_d = StDrop;
          else if (head_is_mem) state_d = StMemReq;
          else                  state_d = StExec;
        end
      end
      StDrop:    state_d = StIdle;
      StExec:    state_d = StResult;
      StMemReq:  if (mem_ready)        state_d = StMemWait;
      StMemWait: if (mem_result_valid) state_d = StResult;
      StResult:  if (result_ready)     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_valid     = 1'b0;
    result_valid  = 1'b0;
    pop           = 1'b0;
    res_load_exec = 1'b0;
    res_load_mem  = 1'b0;
    unique case (state_q)
      StIdle:    ;
      StDrop:    pop = 1'b1;
      StExec:    res_load_exec = 1'b1;
      StMemReq:  mem_valid = 1'b1;
      StMemWait: res_load_mem = mem_result_valid;
      StResult: begin
        result_valid = 1'b1;
        pop          = result_ready;
      end
      default:   ;
    endcase
  end

  // Request fields are gated so the bus idles at zero between requests.
  assign mem_id    = mem_valid ? head_id : '0;
  assign mem_addr  = mem_valid ? head_rs0 : '0;
  assign mem_wdata = mem_valid ? head_rs1 : '0;
  assign mem_we    = mem_valid & (head_op == OpStore);
  assign mem_be    = {(XLEN/8){mem_valid}};

  // ---------------------------------------------------------------------------
  // Result registers: loaded once per instruction, held until accepted
  // ---------------------------------------------------------------------------
  logic [X_ID_WIDTH-1:0] res_id_q;
  logic [XLEN-1:0]       res_data_q;
  logic [4:0]            res_rd_q;
  logic                  res_we_q, res_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_id_q   <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      res_we_q   <= 1'b0;
      res_err_q  <= 1'b0;
    end else if (res_load_exec) begin
      res_id_q   <= head_id;
      res_data_q <= alu_result;
      res_rd_q   <= head_rd;
      res_we_q   <= 1'b1;
      res_err_q  <= 1'b0;
    end else if (res_load_mem) begin
      res_id_q   <= head_id;
      res_data_q <= (head_op == OpLoad) ? mem_rdata : '0;
      res_rd_q   <= head_rd;
      res_we_q   <= (head_op == OpLoad) & ~mem_result_err;
      res_err_q  <= mem_result_err;
    end
  end

  assign result_id   = res_id_q;
  assign result_data = res_data_q;
  assign result_rd   = res_rd_q;
  assign result_we   = res_we_q;
  assign result_err  = res_err_q;

endmodule

// File: tb/tb_xif_coproc_pipe.sv
// Self-checking bench for xif_coproc_pipe: table of ALU/decode vectors plus
// directed sequences for queue-full, kill, memory stalls, errors and reset.
module tb_xif_coproc_pipe;

  localparam logic [6:0] C0  = 7'b0001011;
  localparam logic [6:0] C1  = 7'b0101011;
  localparam logic [6:0] UNK = 7'b0110011;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic [31:0] issue_rs0, issue_rs1;
  logic        issue_accept, issue_writeback, issue_loadstore;
  logic        commit_valid, commit_kill;
  logic [3:0]  commit_id;
  logic        mem_valid, mem_ready, mem_we;
  logic [3:0]  mem_id;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_result_valid, mem_result_err;
  logic [31:0] mem_rdata;
  logic        result_valid, result_ready, result_we, result_err;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;

  xif_coproc_pipe #(
    .DEPTH(4), .X_ID_WIDTH(4), .XLEN(32), .MAGIC(32'hDEADBEEF)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
    .issue_id(issue_id), .issue_rs0(issue_rs0), .issue_rs1(issue_rs1),
    .issue_accept(issue_accept), .issue_writeback(issue_writeback),
    .issue_loadstore(issue_loadstore),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_id(mem_id), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_result_valid(mem_result_valid), .mem_rdata(mem_rdata),
    .mem_result_err(mem_result_err),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_data(result_data), .result_rd(result_rd), .result_we(result_we),
    .result_err(result_err)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs0;
    logic [31:0] rs1;
    logic        acc;
    logic        wb;
    logic        ls;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {17'd0, f3, rd, opc};
  endfunction

  // Drives one issue cycle starting at a negedge; returns the combinational response.
  task automatic do_issue(input logic [31:0] instr, input logic [3:0] id,
                          input logic [31:0] rs0, input logic [31:0] rs1,
                          output logic acc, output logic wb, output logic ls);
    issue_valid = 1'b1;
    issue_instr = instr;
    issue_id    = id;
    issue_rs0   = rs0;
    issue_rs1   = rs1;
    #1;
    acc = issue_accept;
    wb  = issue_writeback;
    ls  = issue_loadstore;
    @(negedge clk_i);
    issue_valid = 1'b0;
    issue_instr = '0;
  endtask

  task automatic do_commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    @(negedge clk_i);
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
  endtask

  // Waits (bounded) for the next result, checks it, and leaves result_ready high.
  task automatic wait_result(input string name, input logic [3:0] id, input logic [4:0] rd,
                             input logic [31:0] data, input logic we, input logic err);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_i);
      if (result_valid) seen = 1'b1;
    end
    check({name, " valid"}, 64'(seen), 64'd1);
    if (seen) begin
      check({name, " id/rd"}, {result_id, result_rd}, {id, rd});
      check({name, " data"}, result_data, data);
      check({name, " we/err"}, {result_we, result_err}, {we, err});
      result_ready = 1'b1;
    end
  endtask

  task automatic expect_no_result(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk_i);
      if (result_valid) seen++;
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, wb, ls;
    logic [3:0] id;

    vecs[0] = '{mk(C0, 3'b000, 5'd1),  32'h1,        32'h2,        1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{mk(C0, 3'b001, 5'd5),  32'hFFFFFFFF, 32'h2,        1'b1, 1'b1, 1'b0, 32'h1};
    vecs[2] = '{mk(C0, 3'b001, 5'd6),  32'h12345678, 32'h11111111, 1'b1, 1'b1, 1'b0, 32'h23456789};
    vecs[3] = '{mk(C0, 3'b010, 5'd7),  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b1, 1'b0, 32'h0FF00FF0};
    vecs[4] = '{mk(C0, 3'b011, 5'd8),  32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 32'h80000000};
    vecs[5] = '{mk(C0, 3'b011, 5'd9),  32'h5,        32'h9,        1'b1, 1'b1, 1'b0, 32'h9};
    vecs[6] = '{mk(UNK, 3'b000, 5'd10), 32'h1,       32'h1,        1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{mk(C0, 3'b100, 5'd11), 32'h1,        32'h1,        1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{mk(C1, 3'b010, 5'd12), 32'h1,        32'h1,        1'b0, 1'b0, 1'b0, 32'h0};

    issue_valid = 0; issue_instr = '0; issue_id = '0; issue_rs0 = '0; issue_rs1 = '0;
    commit_valid = 0; commit_id = '0; commit_kill = 0;
    mem_ready = 0; mem_result_valid = 0; mem_rdata = '0; mem_result_err = 0;
    result_ready = 1'b1;

    // Reset state
    #1 rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset issue", {issue_ready, issue_accept, issue_writeback, issue_loadstore}, 4'b1000);
    check("reset mem ctl", {mem_valid, mem_we, mem_be, mem_id}, 10'd0);
    check("reset mem data", {mem_addr, mem_wdata}, 64'd0);
    check("reset result ctl", {result_valid, result_we, result_err, result_id, result_rd}, 12'd0);
    check("reset result data", result_data, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // ADD with wrap; result_valid exactly two cycles after the commit
    do_issue(mk(C0, 3'b001, 5'd5), 4'd0, 32'hFFFFFFFF, 32'd2, acc, wb, ls);
    check("add response", {acc, wb, ls}, 3'b110);
    do_commit(4'd0, 1'b0);
    check("add t+1 no result", result_valid, 1'b0);
    @(negedge clk_i);
    check("add t+2 valid", result_valid, 1'b1);
    check("add fields", {result_data, result_id, result_rd, result_we, result_err},
          {32'd1, 4'd0, 5'd5, 1'b1, 1'b0});
    @(negedge clk_i);
    check("add single pulse", result_valid, 1'b0);

    // Table-driven decode/ALU vectors
    for (int i = 0; i < 9; i++) begin
      id = 4'(i + 1);
      do_issue(vecs[i].instr, id, vecs[i].rs0, vecs[i].rs1, acc, wb, ls);
      check($sformatf("vec%0d response", i), {acc, wb, ls}, {vecs[i].acc, vecs[i].wb, vecs[i].ls});
      do_commit(id, 1'b0);
      if (vecs[i].acc) begin
        wait_result($sformatf("vec%0d", i), id, vecs[i].instr[11:7], vecs[i].data, 1'b1, 1'b0);
      end else begin
        expect_no_result($sformatf("vec%0d rejected no result", i), 5);
        check($sformatf("vec%0d ready", i), issue_ready, 1'b1);
      end
    end

    // Fill the queue, then drain in order
    result_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      do_issue(mk(C0, 3'b001, 5'(i)), 4'(i), 32'(i), 32'd10, acc, wb, ls);
    end
    check("full ready low", issue_ready, 1'b0);
    for (int i = 1; i <= 4; i++) do_commit(4'(i), 1'b0);
    for (int i = 1; i <= 4; i++) begin
      wait_result($sformatf("drain%0d", i), 4'(i), 5'(i), 32'(10 + i), 1'b1, 1'b0);
    end
    @(negedge clk_i);
    check("drain ready back", issue_ready, 1'b1);

    // Kill one, commit the other
    do_issue(mk(C0, 3'b000, 5'd3), 4'd5, 32'd0, 32'd0, acc, wb, ls);
    do_issue(mk(C0, 3'b000, 5'd4), 4'd6, 32'd0, 32'd0, acc, wb, ls);
    do_commit(4'd5, 1'b1);
    do_commit(4'd6, 1'b0);
    wait_result("kill survivor", 4'd6, 5'd4, 32'hDEADBEEF, 1'b1, 1'b0);
    expect_no_result("killed no result", 4);

    // RMST with mem_ready low for 3 cycles
    do_issue(mk(C1, 3'b001, 5'd0), 4'd7, 32'h100, 32'hCAFE, acc, wb, ls);
    check("rmst response", {acc, wb, ls}, 3'b101);
    do_commit(4'd7, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rmst req%0d ctl", k), {mem_valid, mem_we, mem_be, mem_id},
            {1'b1, 1'b1, 4'hF, 4'd7});
      check($sformatf("rmst req%0d data", k), {mem_addr, mem_wdata}, {32'h100, 32'hCAFE});
      if (k == 3) mem_ready = 1'b1;
      @(negedge clk_i);
    end
    mem_ready = 1'b0;
    check("rmst req dropped", mem_valid, 1'b0);
    mem_result_valid = 1'b1; mem_rdata = 32'h1234;
    @(negedge clk_i);
    mem_result_valid = 1'b0; mem_rdata = '0;
    check("rmst result", {result_valid, result_we, result_err, result_id},
          {1'b1, 1'b0, 1'b0, 4'd7});
    check("rmst data", result_data, 32'd0);
    @(negedge clk_i);

    // RMLD with bus error, result held while result_ready is low
    result_ready = 1'b0;
    do_issue(mk(C1, 3'b000, 5'd9), 4'd8, 32'h200, 32'd0, acc, wb, ls);
    check("rmld response", {acc, wb, ls}, 3'b111);
    do_commit(4'd8, 1'b0);
    check("rmld req", {mem_valid, mem_we, mem_addr}, {1'b1, 1'b0, 32'h200});
    mem_ready = 1'b1;
    @(negedge clk_i);
    mem_ready = 1'b0;
    mem_result_valid = 1'b1; mem_result_err = 1'b1; mem_rdata = 32'hAAAA5555;
    @(negedge clk_i);
    mem_result_valid = 1'b0; mem_result_err = 1'b0; mem_rdata = '0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rmld hold%0d", k), {result_valid, result_we, result_err, result_id, result_rd},
            {1'b1, 1'b0, 1'b1, 4'd8, 5'd9});
      check($sformatf("rmld hold%0d data", k), result_data, 32'hAAAA5555);
      if (k == 2) result_ready = 1'b1;
      @(negedge clk_i);
    end
    check("rmld accepted", result_valid, 1'b0);

    // Reset while an RMLD request is outstanding
    do_issue(mk(C1, 3'b000, 5'd2), 4'd9, 32'h300, 32'd0, acc, wb, ls);
    do_commit(4'd9, 1'b0);
    check("pre-reset mem_valid", mem_valid, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid reset mem", {mem_valid, mem_be, mem_addr}, 37'd0);
    check("mid reset result", {result_valid, result_err, result_we, result_id}, 7'd0);
    check("mid reset data", result_data, 32'd0);
    check("mid reset ready", issue_ready, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    do_commit(4'd9, 1'b0);
    expect_no_result("post reset queue empty", 4);
    do_issue(mk(C0, 3'b010, 5'd1), 4'd3, 32'h0F, 32'hF0, acc, wb, ls);
    do_commit(4'd3, 1'b0);
    wait_result("post reset xor", 4'd3, 5'd1, 32'hFF, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
